// File: rtl/mem_pkg.sv
// Shared types for the memory-port arbiter: size codes, owner and state
// encodings, and the one-hot grant bundle produced by the picker.
package mem_pkg;

  localparam logic [2:0] LEN_LB  = 3'b000;
  localparam logic [2:0] LEN_LH  = 3'b001;
  localparam logic [2:0] LEN_LW  = 3'b010;
  localparam logic [2:0] LEN_LBU = 3'b100;
  localparam logic [2:0] LEN_LHU = 3'b101;

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_INST,
    OWN_LOAD,
    OWN_STORE
  } owner_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DRAIN
  } state_e;

  typedef struct packed {
    logic st;
    logic ld;
    logic inst;
  } grant_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Priority picker: store > load > inst, unless inst has been starved,
// in which case a pending inst request jumps to the front.
module mem_arb_pick
  import mem_pkg::*;
(
  input  logic   inst_v_i,
  input  logic   ld_v_i,
  input  logic   st_v_i,
  input  logic   starve_i,
  output grant_t grant_o
);

  always_comb begin
    grant_o = '0;
    if (starve_i && inst_v_i) begin
      grant_o.inst = 1'b1;
    end else if (st_v_i) begin
      grant_o.st = 1'b1;
    end else if (ld_v_i) begin
      grant_o.ld = 1'b1;
    end else if (inst_v_i) begin
      grant_o.inst = 1'b1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory_controller port among inst fill, load and store drain;
// one transaction in flight, flush aborts reads but lets stores finish.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clear,
  input  logic              inst_valid,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_ready,
  output logic [31:0]       inst_res,
  input  logic              ld_valid,
  input  logic [2:0]        ld_type,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic              ld_ready,
  output logic [31:0]       ld_res,
  input  logic              st_valid,
  input  logic [2:0]        st_type,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  output logic              st_ready,
  output logic              mc_valid,
  output logic              mc_wr,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [2:0]        mc_len,
  output logic [31:0]       mc_data,
  output logic              mc_abort,
  input  logic              mc_ready,
  input  logic [31:0]       mc_res
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic [3:0]        skip_q, skip_d;
  logic              mc_valid_q, mc_valid_d;
  logic              mc_wr_q, mc_wr_d;
  logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
  logic [2:0]        mc_len_q, mc_len_d;
  logic [31:0]       mc_data_q, mc_data_d;
  logic              mc_abort_q, mc_abort_d;

  grant_t grant;
  logic   starve;
  logic   any_req;
  logic   kill;
  logic   fire;

  assign starve  = (skip_q == 4'(STARVE_LIMIT));
  assign any_req = inst_valid | ld_valid | st_valid;
  // A flush kills speculative reads only; stores always run to completion.
  assign kill    = clear && (state_q == ST_BUSY)
                   && (owner_q != OWN_STORE);

  mem_arb_pick u_pick (
    .inst_v_i (inst_valid),
    .ld_v_i   (ld_valid),
    .st_v_i   (st_valid),
    .starve_i (starve),
    .grant_o  (grant)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    skip_d     = skip_q;
    mc_valid_d = mc_valid_q;
    mc_wr_d    = mc_wr_q;
    mc_addr_d  = mc_addr_q;
    mc_len_d   = mc_len_q;
    mc_data_d  = mc_data_q;
    mc_abort_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!clear && any_req) begin
          state_d    = ST_BUSY;
          mc_valid_d = 1'b1;
          if (grant.st) begin
            owner_d   = OWN_STORE;
            mc_wr_d   = 1'b1;
            mc_addr_d = st_addr;
            mc_len_d  = st_type;
            mc_data_d = st_data;
          end else if (grant.ld) begin
            owner_d   = OWN_LOAD;
            mc_wr_d   = 1'b0;
            mc_addr_d = ld_addr;
            mc_len_d  = ld_type;
            mc_data_d = '0;
          end else begin
            owner_d   = OWN_INST;
            mc_wr_d   = 1'b0;
            mc_addr_d = inst_addr;
            mc_len_d  = LEN_LW;
            mc_data_d = '0;
          end
          if (inst_valid) begin
            if (grant.inst) begin
              skip_d = '0;
            end else if (skip_q != 4'hF) begin
              skip_d = skip_q + 4'd1;
            end
          end
        end
      end
      ST_BUSY: begin
        if (kill) begin
          state_d    = ST_IDLE;
          owner_d    = OWN_NONE;
          mc_valid_d = 1'b0;
          mc_abort_d = 1'b1;
        end else if (mc_ready) begin
          state_d    = ST_IDLE;
          owner_d    = OWN_NONE;
          mc_valid_d = 1'b0;
        end else if (clear) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mc_ready) begin
          state_d    = ST_IDLE;
          owner_d    = OWN_NONE;
          mc_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        owner_d = OWN_NONE;
      end
    endcase
    if (!inst_valid) begin
      skip_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      owner_q    <= OWN_NONE;
      skip_q     <= '0;
      mc_valid_q <= 1'b0;
      mc_wr_q    <= 1'b0;
      mc_addr_q  <= '0;
      mc_len_q   <= '0;
      mc_data_q  <= '0;
      mc_abort_q <= 1'b0;
    end else if (rdy) begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      skip_q     <= skip_d;
      mc_valid_q <= mc_valid_d;
      mc_wr_q    <= mc_wr_d;
      mc_addr_q  <= mc_addr_d;
      mc_len_q   <= mc_len_d;
      mc_data_q  <= mc_data_d;
      mc_abort_q <= mc_abort_d;
    end
  end

  assign fire = rdy && mc_ready && (state_q != ST_IDLE) && !kill;

  assign inst_ready = fire && (owner_q == OWN_INST);
  assign ld_ready   = fire && (owner_q == OWN_LOAD);
  assign st_ready   = fire && (owner_q == OWN_STORE);
  assign inst_res   = mc_res;
  assign ld_res     = mc_res;

  assign mc_valid = mc_valid_q;
  assign mc_wr    = mc_wr_q;
  assign mc_addr  = mc_addr_q;
  assign mc_len   = mc_len_q;
  assign mc_data  = mc_data_q;
  assign mc_abort = mc_abort_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences the single shared memory_controller port among three requesters: instruction-cache miss fill, LSB load, and committed-store drain.
- One transaction in flight at a time.
- Uses a fixed store > load > inst priority, with a starvation guard for instruction fetch.
- Handles pipeline flush (clear): speculative reads are aborted; committed stores always complete.
- Sits between the cache/LSB front end and memory_controller.

Parameters:
- STARVE_LIMIT, 4: consecutive grants inst may lose before it is forced to top priority (1..15).
- ADDR_W, 32: address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global enable; low freezes all state
- clear  in  1  pipeline flush
- inst_valid  in  1  instruction fill request
- inst_addr  in  ADDR_W  word address to fill
- inst_ready  out  1  one-cycle done pulse
- inst_res  out  32  fetched word
- ld_valid  in  1  load request
- ld_type  in  3  funct3 size/sign code
- ld_addr  in  ADDR_W  load address
- ld_ready  out  1  one-cycle done pulse
- ld_res  out  32  load data from controller
- st_valid  in  1  store request
- st_type  in  3  size code
- st_addr  in  ADDR_W  store address
- st_data  in  32  store data
- st_ready  out  1  one-cycle done pulse
- mc_valid  out  1  request to memory_controller
- mc_wr  out  1  1 = write
- mc_addr  out  ADDR_W  address
- mc_len  out  3  size code
- mc_data  out  32  write data
- mc_abort  out  1  one-cycle abort pulse to controller
- mc_ready  in  1  controller done pulse
- mc_res  in  32  controller read data

Behaviour:
- Reset: state IDLE, owner NONE, skip_cnt 0. All outputs 0: mc_valid, mc_wr, mc_addr, mc_len, mc_data, mc_abort, every *_ready.
- Reset mid-transaction drops everything; no mc_abort is issued.
- rdy=0: no state or register changes. Registered outputs hold. Combinational *_ready outputs forced 0.
- Requester contract: hold valid and fields stable until its ready pulse. Ready is asserted for exactly one cycle, in the same cycle mc_ready is seen.
- States: IDLE, BUSY, DRAIN.
- IDLE, no clear, a request pending:
  - Latch the winner's fields into mc_* registers; mc_valid=1 next cycle; owner = winner; go to BUSY.
  - mc_len for inst is fixed at 3'b010; mc_wr=1 only for store.
  - Latency: request in cycle N -> mc_valid high in cycle N+1.
- Winner selection: skip_cnt==STARVE_LIMIT and inst_valid -> inst. Otherwise store > load > inst.
- skip_cnt:
  - Increments (saturating) when inst_valid=1 and another requester is granted.
  - Clears when inst is granted or inst_valid=0.
- BUSY:
  - mc_valid held until mc_ready.
  - On mc_ready: owner's ready pulses combinationally; res = mc_res (ld_res, inst_res driven from mc_res). Next cycle mc_valid=0, state IDLE.
  - Earliest back-to-back: next mc_valid two cycles after mc_ready.
- clear, IDLE: no grant that cycle. The store request stays pending and is granted the next non-clear cycle.
- clear, BUSY with owner inst or load:
  - Suppress the owner's ready even if mc_ready coincides.
  - Next cycle: mc_valid=0, mc_abort=1 (one cycle), state IDLE, owner NONE.
- clear, BUSY with owner store: go to DRAIN. mc_valid stays high; the store completes normally; st_ready pulses on mc_ready; then IDLE.
- clear during DRAIN: ignored.
- mc_ready in IDLE (spurious): ignored; no ready pulses.
- Only one *_ready is ever high in a cycle.

Decomposition:
- Shared package mem_pkg:
  - len codes: LB=000, LH=001, LW=010, LBU=100, LHU=101
  - owner enum: NONE, INST, LOAD, STORE
  - state enum: IDLE, BUSY, DRAIN
- One natural sub-module, mem_arb_pick: combinational priority/starvation picker. Inputs: three valids and skip_cnt==STARVE_LIMIT. Output: one-hot grant.

Test Plan:
- inst_valid only, addr 0x1000; mc_ready 3 cycles after mc_valid with mc_res 0xDEADBEEF -> mc_len=010, mc_wr=0; inst_ready one cycle with inst_res 0xDEADBEEF; mc_valid drops next cycle.
- st_valid, ld_valid, inst_valid all high in the same cycle (st 0x2000 data 0x55 type 000) -> grant order store, load, inst; skip_cnt reaches 2.
- ld_valid and st_valid held continuously plus inst_valid, STARVE_LIMIT=4 -> inst wins the 5th grant; skip_cnt returns to 0.
- Load in BUSY, clear coincident with mc_ready -> ld_ready stays 0; mc_abort=1 next cycle; state IDLE; a new inst request is granted after that.
- Store in BUSY, clear asserted -> mc_valid stays 1; st_ready pulses on mc_ready; no mc_abort.
- rdy low for 5 cycles mid-BUSY with mc_ready pulsed while rdy=0 -> no ready pulse, state unchanged; rst mid-BUSY -> all outputs 0 the next cycle.
